effect_sample_sequencer: RTL and testbench

Sample-side counterpart of the floating-point effect stages. It presents one IEEE-754 single-precision sample to an effect's input and holds it stable. It waits for the effect's periodic ready strobe, then reads the processed result and forwards it downstream as a one-cycle valid pulse. It also handles the effect's post-reset priming period, lost or late results (timeout with dry fallback), and samples that arrive while a read is outstanding (overrun).

---
 rtl/effect_sample_sequencer.sv | 115 +++++++++++
 tb/tb_effect_sample_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/effect_sample_sequencer.sv
// Sample-side sequencer for a floating-point effect stage: holds one sample on the effect input,
// collects the processed result on the effect's ready strobe, and falls back to the dry sample on timeout.
module effect_sample_sequencer #(
   parameter int unsigned MIN_LAT = 9,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        aclr,
   input  logic        sample_valid,
   input  logic [31:0] sample_in,
   input  logic        effect_ready,
   input  logic [31:0] effect_out,
   input  logic        clear_err,
   output logic [31:0] effect_in,
   output logic [31:0] sample_out,
   output logic        sample_out_valid,
   output logic        busy,
   output logic        primed,
   output logic        timeout_err,
   output logic [7:0]  overrun_cnt
);

   typedef enum logic [1:0] {S_PRIME, S_IDLE, S_WAIT} state_t;

   localparam logic [7:0] MIN_LAT_C = 8'(MIN_LAT);
   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t      r_state;
   logic [7:0]  r_lat_cnt;
   logic [31:0] r_effect_in;
   logic [31:0] r_sample_out;
   logic        r_sample_out_valid;
   logic        r_busy;
   logic        r_primed;
   logic        r_timeout_err;
   logic [7:0]  r_overrun_cnt;
   logic        w_capture;

   // Strobes arriving before MIN_LAT belong to the previous sample still draining out of the effect.
   assign w_capture = effect_ready && (r_lat_cnt >= MIN_LAT_C);

   // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         r_state            <= S_PRIME;
         r_lat_cnt          <= 8'd0;
         r_effect_in        <= 32'd0;
         r_sample_out       <= 32'd0;
         r_sample_out_valid <= 1'b0;
         r_busy             <= 1'b0;
         r_primed           <= 1'b0;
         r_timeout_err      <= 1'b0;
         r_overrun_cnt      <= 8'd0;
      end else begin
         r_sample_out_valid <= 1'b0;
         case (r_state)
            S_PRIME: begin
               if (sample_valid) begin
                  r_sample_out       <= sample_in;
                  r_sample_out_valid <= 1'b1;
               end
               if (effect_ready) begin
                  r_primed <= 1'b1;
                  r_state  <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (sample_valid) begin
                  r_effect_in <= sample_in;
                  r_lat_cnt   <= 8'd0;
                  r_busy      <= 1'b1;
                  r_state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (w_capture) begin
                  r_sample_out       <= effect_out;
                  r_sample_out_valid <= 1'b1;
                  r_busy             <= 1'b0;
                  r_state            <= S_IDLE;
               end else if (r_lat_cnt == TIMEOUT_C) begin
                  r_sample_out       <= r_effect_in;
                  r_sample_out_valid <= 1'b1;
                  r_timeout_err      <= 1'b1;
                  r_busy             <= 1'b0;
                  r_state            <= S_IDLE;
               end else if (r_lat_cnt != 8'hFF) begin
                  r_lat_cnt <= r_lat_cnt + 8'd1;
               end
               if (sample_valid && (r_overrun_cnt != 8'hFF)) begin
                  r_overrun_cnt <= r_overrun_cnt + 8'd1;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_PRIME;
            end
         endcase
         // Placed last so a clear overrides any set or increment in the same cycle.
         if (clear_err) begin
            r_timeout_err <= 1'b0;
            r_overrun_cnt <= 8'd0;
         end
      end
   end

   assign effect_in        = r_effect_in;
   assign sample_out       = r_sample_out;
   assign sample_out_valid = r_sample_out_valid;
   assign busy             = r_busy;
   assign primed           = r_primed;
   assign timeout_err      = r_timeout_err;
   assign overrun_cnt      = r_overrun_cnt;

endmodule

// File: tb/tb_effect_sample_sequencer.sv
// Directed and randomized bench for effect_sample_sequencer, checked against a transaction-level model
// that tracks the age of the outstanding sample rather than a state machine.
module tb_effect_sample_sequencer;

   localparam int MIN_LAT = 9;
   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        aclr = 1'b0;
   logic        sample_valid = 1'b0;
   logic [31:0] sample_in = 32'd0;
   logic        effect_ready = 1'b0;
   logic [31:0] effect_out = 32'd0;
   logic        clear_err = 1'b0;
   logic [31:0] effect_in;
   logic [31:0] sample_out;
   logic        sample_out_valid;
   logic        busy;
   logic        primed;
   logic        timeout_err;
   logic [7:0]  overrun_cnt;

   effect_sample_sequencer #(.MIN_LAT(MIN_LAT), .TIMEOUT(TIMEOUT)) dut (
      .clk              (clk),
      .aclr             (aclr),
      .sample_valid     (sample_valid),
      .sample_in        (sample_in),
      .effect_ready     (effect_ready),
      .effect_out       (effect_out),
      .clear_err        (clear_err),
      .effect_in        (effect_in),
      .sample_out       (sample_out),
      .sample_out_valid (sample_out_valid),
      .busy             (busy),
      .primed           (primed),
      .timeout_err      (timeout_err),
      .overrun_cnt      (overrun_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: m_age is the age in cycles of the sample held on the effect, -1 when none.
   int          m_age;
   bit          m_primed;
   bit          m_valid;
   bit          m_terr;
   int          m_ovr;
   logic [31:0] m_ein;
   logic [31:0] m_out;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_age = -1; m_primed = 1'b0; m_valid = 1'b0; m_terr = 1'b0;
      m_ovr = 0; m_ein = 32'd0; m_out = 32'd0;
   endtask

   task automatic model_step(input bit sv, input logic [31:0] si, input bit er,
                             input logic [31:0] eo, input bit ce);
      m_valid = 1'b0;
      if (!m_primed) begin
         if (sv) begin m_out = si; m_valid = 1'b1; end
         if (er) m_primed = 1'b1;
      end else if (m_age < 0) begin
         if (sv) begin m_ein = si; m_age = 0; end
      end else begin
         if (sv) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
         if (er && m_age >= MIN_LAT) begin
            m_out = eo; m_valid = 1'b1; m_age = -1;
         end else if (m_age == TIMEOUT) begin
            m_out = m_ein; m_valid = 1'b1; m_terr = 1'b1; m_age = -1;
         end else begin
            m_age++;
         end
      end
      if (ce) begin m_terr = 1'b0; m_ovr = 0; end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".effect_in"},   effect_in,               m_ein);
      check({tag, ".sample_out"},  sample_out,              m_out);
      check({tag, ".valid"},       32'(sample_out_valid),   32'(m_valid));
      check({tag, ".busy"},        32'(busy),               32'(m_age >= 0));
      check({tag, ".primed"},      32'(primed),             32'(m_primed));
      check({tag, ".timeout_err"}, 32'(timeout_err),        32'(m_terr));
      check({tag, ".overrun"},     32'(overrun_cnt),        32'(m_ovr));
   endtask

   // One clock: apply inputs, let the edge take them, then compare against the model.
   task automatic cycle(input string tag, input bit sv, input logic [31:0] si, input bit er,
                        input logic [31:0] eo, input bit ce);
      sample_valid = sv; sample_in = si; effect_ready = er; effect_out = eo; clear_err = ce;
      @(posedge clk);
      model_step(sv, si, er, eo, ce);
      #1;
      sample_valid = 1'b0; effect_ready = 1'b0; clear_err = 1'b0;
      check_all(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) cycle(tag, 1'b0, $urandom(), 1'b0, $urandom(), 1'b0);
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      aclr = 1'b1;
      idle("post_reset", 2);

      // 1: dry pass-through while priming
      cycle("t1", 1'b1, 32'h3F00_0000, 1'b0, 32'd0, 1'b0);
      check("t1.out_lit", sample_out, 32'h3F00_0000);
      check("t1.valid_lit", 32'(sample_out_valid), 32'd1);
      check("t1.effect_in_lit", effect_in, 32'd0);
      idle("t1.after", 1);

      // 2: prime, load, early strobe ignored, strobe at lat 9 captured
      cycle("t2.prime", 1'b0, 32'd0, 1'b1, 32'd0, 1'b0);
      check("t2.primed_lit", 32'(primed), 32'd1);
      cycle("t2.load", 1'b1, 32'hBF00_0000, 1'b0, 32'd0, 1'b0);
      check("t2.ein_lit", effect_in, 32'hBF00_0000);
      check("t2.busy_lit", 32'(busy), 32'd1);
      idle("t2.wait", 4);
      cycle("t2.early", 1'b0, 32'd0, 1'b1, 32'h1234_5678, 1'b0);
      check("t2.early_busy", 32'(busy), 32'd1);
      idle("t2.wait2", 4);
      cycle("t2.cap", 1'b0, 32'd0, 1'b1, 32'hBE80_0000, 1'b0);
      check("t2.out_lit", sample_out, 32'hBE80_0000);
      check("t2.busy_low", 32'(busy), 32'd0);
      idle("t2.after", 1);
      check("t2.single_pulse", 32'(sample_out_valid), 32'd0);

      // 3: timeout falls back to the dry sample
      cycle("t3.load", 1'b1, 32'h4000_0000, 1'b0, 32'd0, 1'b0);
      idle("t3.wait", TIMEOUT);
      check("t3.still_busy", 32'(busy), 32'd1);
      idle("t3.to", 1);
      check("t3.out_lit", sample_out, 32'h4000_0000);
      check("t3.terr_lit", 32'(timeout_err), 32'd1);
      idle("t3.after", 1);
      cycle("t3.clear", 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      check("t3.terr_clr", 32'(timeout_err), 32'd0);

      // 4: overrun counting, including a drop on the capture cycle, then saturation
      cycle("t4.load", 1'b1, 32'hC0A0_0000, 1'b0, 32'd0, 1'b0);
      idle("t4.w", 2);
      cycle("t4.drop1", 1'b1, 32'h1111_1111, 1'b0, 32'd0, 1'b0);
      idle("t4.w", 1);
      cycle("t4.drop2", 1'b1, 32'h2222_2222, 1'b0, 32'd0, 1'b0);
      idle("t4.w", 4);
      cycle("t4.cap", 1'b1, 32'h3333_3333, 1'b1, 32'h4110_0000, 1'b0);
      check("t4.ovr_lit", 32'(overrun_cnt), 32'd3);
      check("t4.ein_lit", effect_in, 32'hC0A0_0000);
      check("t4.out_lit", sample_out, 32'h4110_0000);
      for (int i = 0; i < 320; i++) cycle("t4.flood", 1'b1, $urandom(), 1'b0, 32'd0, 1'b0);
      check("t4.ovr_sat", 32'(overrun_cnt), 32'd255);
      idle("t4.drain", TIMEOUT + 2);
      cycle("t4.clear", 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);

      // 5: capture and timeout coincide -> capture wins
      cycle("t5.load", 1'b1, 32'h4080_0000, 1'b0, 32'd0, 1'b0);
      idle("t5.wait", TIMEOUT);
      cycle("t5.both", 1'b0, 32'd0, 1'b1, 32'h3E00_0000, 1'b0);
      check("t5.out_lit", sample_out, 32'h3E00_0000);
      check("t5.terr_lit", 32'(timeout_err), 32'd0);

      // 6: asynchronous reset in the middle of a wait
      cycle("t6.load", 1'b1, 32'h4248_0000, 1'b0, 32'd0, 1'b0);
      idle("t6.wait", 20);
      #2 aclr = 1'b0;
      #1;
      model_reset();
      check_all("t6.async");
      check("t6.out_zero", sample_out, 32'd0);
      @(posedge clk);
      #1;
      check_all("t6.held");
      aclr = 1'b1;
      idle("t6.release", 1);
      check("t6.primed_lit", 32'(primed), 32'd0);
      cycle("t6.dry", 1'b1, 32'h3F80_0000, 1'b0, 32'd0, 1'b0);
      check("t6.dry_lit", sample_out, 32'h3F80_0000);

      // Randomized traffic with occasional clears
      for (int i = 0; i < 3000; i++) begin
         cycle("rand", ($urandom_range(7) == 0), $urandom(), ($urandom_range(11) == 0),
               $urandom(), ($urandom_range(63) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
